count4: RTL and testbench
=========================

COUNT4 -- requirements
Module: count4

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 1..32.
REQ-002 Parameter RESET_VAL, default 0: value loaded on reset; SHALL be taken modulo 2^WIDTH.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port out, output, WIDTH bits (4 by default): current count, driven directly from a register.
REQ-006 Positional port order SHALL be (out, reset, clk) so that positional instantiation binds correctly.
REQ-007 The block SHALL contain no other ports, clocks or resets.

Function
REQ-008 Counting: on each rising clk edge with reset low, out SHALL become (out + 1) mod 2^WIDTH.
REQ-009 Latency: the new value SHALL appear on out immediately after the clock edge, with zero added cycles.
REQ-010 Wrap-around: with WIDTH=4, out SHALL go from 15 to 0 and continue with no stall, flag or skipped value.
REQ-011 Out-of-reset: the first rising edge after reset deasserts SHALL produce RESET_VAL+1.
REQ-012 Simultaneous events: if reset is high at a rising clk edge, including the same simulation timestep, reset SHALL win and out SHALL stay at RESET_VAL.
REQ-013 Mid-operation reset: asserting reset at any count SHALL force out to RESET_VAL at once, with no clock required.
REQ-014 No increment SHALL occur while reset is high.
REQ-015 out SHALL never be X or Z after the first reset assertion.
REQ-016 Arithmetic SHALL be unsigned, and the increment carry SHALL be discarded.

Reset
REQ-017 While reset=1, out SHALL equal RESET_VAL (0 by default) regardless of clk.
REQ-018 Reset assertion SHALL take effect asynchronously, within the same timestep as the reset rising edge.
REQ-019 Reset deassertion SHALL take effect at the next rising clk edge.
REQ-020 The value of out before the first reset assertion is unspecified.
REQ-021 The testbench SHALL assert reset before checking out.

Verification
REQ-022 Power-up reset:
- Stimulus: clk period 20 ns starting low; reset=1 from t=10 to t=20 ns.
- Response: out=0 from t=10 ns, including the clk rising edge at t=10 ns.
REQ-023 Count sequence:
- Stimulus: after reset release at t=20 ns.
- Response: rising edges at t=30, 50, 70 ns give out=1, 2, 3; the 15th edge after release gives out=15.
REQ-024 Wrap-around:
- Stimulus: the 16th edge after release (t=330 ns).
- Response: out=0; the 17th edge gives out=1.
REQ-025 Asynchronous mid-count reset:
- Stimulus: count at 9; pulse reset high between clock edges.
- Response: out=0 within the same timestep, before any clk edge; counting resumes 1, 2, ... after release.
REQ-026 Reset held across edges:
- Stimulus: reset=1 for 5 rising edges.
- Response: out stays 0 throughout.
REQ-027 Long run:
- Stimulus: 50 free-running cycles from reset (the 1000 ns window).
- Response: out = (edge count) mod 16 at every edge, no X values.

Source files
------------

// File: rtl/count4.sv
// Free-running unsigned up-counter with an asynchronous, active-high reset.
// The count register drives the output port directly, so a new value is visible right after the edge.
module count4 #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    output logic [WIDTH-1:0] out,
    input  logic             reset,
    input  logic             clk
);

    // Reset value reduced modulo 2^WIDTH by truncation to the counter width
    localparam logic [WIDTH-1:0] RESET_VAL_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    always_comb begin
        out_d = out_q + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= RESET_VAL_W;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_count4.sv
// Directed bench for count4: reset timing, counting, wrap, async and held reset, long run.
module tb_count4;

    logic       clk;
    logic       reset;
    logic [3:0] out;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    count4 dut (
        .out  (out),
        .reset(reset),
        .clk  (clk)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (%b) expected %0d at t=%0t", name, act, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;

        // Counting after release: edges 1..17 give 1..15, 0, 1
        for (int i = 1; i <= 17; i++) vecs.push_back('{1'b0, 4'(i % 16)});
        // Reset held across five edges
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 4'd0});
        // Restart after release
        vecs.push_back('{1'b0, 4'd1});
        vecs.push_back('{1'b0, 4'd2});
        vecs.push_back('{1'b0, 4'd3});

        // Power-up reset rises together with the clk edge at t=10
        #10 reset = 1'b1;
        #1 check("powerup_reset_t11", out, 4'd0);
        #8 check("powerup_reset_t19", out, 4'd0);
        #1 reset = 1'b0;  // t=20, a falling clk edge

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), out, vecs[i].exp);
            @(negedge clk);
        end

        // Advance to a count of 9, then reset between edges
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (out == 4'd9) found = 1'b1;
        end
        check("reach_nine", out, 4'd9);
        #5 reset = 1'b1;
        #1 check("async_midcount_reset", out, 4'd0);
        #1 check("async_reset_hold", out, 4'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 check("resume_1", out, 4'd1);
        @(posedge clk);
        #1 check("resume_2", out, 4'd2);

        // Long run from a fresh reset
        @(negedge clk);
        reset = 1'b1;
        #1 check("longrun_reset", out, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1 check($sformatf("longrun_edge%0d", k), out, 4'(k % 16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
